button_debounce: RTL and testbench
==================================

# button_debounce

Input-side companion to the board LED/counter logic: conditions the raw iCEBreaker pushbuttons (btn1..btn3 active-high, btn_n active-low) into clean logical levels. For each button it produces single-cycle press/release/long-press pulses and keeps a running press count. It sits directly behind the top-level pads, in the global-buffered `clk` domain, and feeds user logic that would otherwise sample the raw buttons.

## Interface
- `N_BTN`, 4: number of button channels.
- `ACTIVE_LOW_MASK`, 4'b1000: bit i set means `btn_raw[i]` is active-low (the btn_n position).
- `LOG2DEBOUNCE`, 16: debounce window is 2^LOG2DEBOUNCE cycles.
- `LOG2LONG`, 23: long-press threshold is 2^LOG2LONG cycles of stable press.

- `clk`  in  1  system clock (post SB_GB).
- `rst`  in  1  asynchronous, active-high reset.
- `btn_raw`  in  N_BTN  raw pad levels, asynchronous to `clk`.
- `btn_level`  out  N_BTN  debounced logical level, 1 = pressed.
- `btn_press`  out  N_BTN  1-cycle pulse on a debounced 0→1 transition.
- `btn_release`  out  N_BTN  1-cycle pulse on a debounced 1→0 transition.
- `btn_long`  out  N_BTN  1-cycle pulse when a press has lasted 2^LOG2LONG cycles.
- `any_pressed`  out  1  OR of `btn_level`.
- `press_count`  out  8  total press events, modulo 256.

## Operation
- Polarity: the logical input is `btn_raw ^ ACTIVE_LOW_MASK`. Everything downstream operates on logical levels.
- Synchronizer: two flops per channel. Both reset to logical 0, i.e. the raw inactive level.
- Debounce counter: one per channel, LOG2DEBOUNCE bits.
  - Cleared on any edge where the synchronized sample equals `btn_level`.
  - Incremented on each edge where they differ.
  - When a mismatch is sampled with the counter at all-ones, `btn_level` toggles and the counter clears.
  - A single matching sample anywhere in the window aborts it: glitches shorter than 2^LOG2DEBOUNCE cycles never propagate.
- Edge pulses: `btn_press` / `btn_release` are registered on the same edge that `btn_level` toggles, and are high for exactly one cycle.
- Long-press FSM, one per channel. States are RELEASED, PRESSED, HELD; reset state is RELEASED.
  - RELEASED→PRESSED on press; the hold counter clears.
  - PRESSED: the hold counter increments each cycle. When it reaches 2^LOG2LONG−1, the FSM goes to HELD and `btn_long` pulses on that transition edge.
  - PRESSED or HELD→RELEASED on release; the hold counter clears.
  - HELD produces no further `btn_long` pulses (no auto-repeat).
- `press_count` adds the popcount of `btn_press` each cycle, modulo 256. Simultaneous presses on k channels add k in one cycle; 255+1 wraps to 0.
- Reset values: all outputs 0, all counters 0, all FSMs RELEASED.
  - Reset mid-press discards the press; no release pulse is emitted.
  - If a button is still held after reset deasserts, it produces a fresh press after the debounce window.

## Timing
- Raw change sampled at edge 0 reaches the sync output at edge 1. Mismatches count at edges 2..1+2^LOG2DEBOUNCE.
- `btn_level` and the press/release pulse therefore update at edge 1+2^LOG2DEBOUNCE, i.e. latency 2^LOG2DEBOUNCE+1 cycles.
- `btn_long` fires 2^LOG2LONG cycles after `btn_press`.
- `press_count` updates one cycle after `btn_press`.
- `any_pressed` is combinational from `btn_level`.
- No handshakes: pulses are fire-and-forget. Consumers sample them every cycle.

## Structure
- Shared package holds:
  - the FSM state enum (RELEASED/PRESSED/HELD, 2 bits);
  - the default constants for LOG2DEBOUNCE and LOG2LONG;
  - `PRESS_COUNT_W` = 8.
- Sub-module `debounce_channel` contains one channel's synchronizer, debounce counter, long-press FSM and pulse outputs.
- The top `button_debounce` instantiates N_BTN channels via generate, and holds the polarity mask, popcount adder and `press_count` register.

## Test plan
Parameters for all scenarios: LOG2DEBOUNCE=3, LOG2LONG=6.

- Reset, then `btn_raw`=4'b1000 idle (btn_n high) → all outputs 0 for 100 cycles; `press_count`=0.
- Assert btn1 cleanly → `btn_level[0]` rises and `btn_press[0]` is one cycle high, exactly 9 cycles after the sampled edge. Deassert → `btn_release[0]` after 9 cycles.
- Toggle btn2 with 5-cycle high / 2-cycle low bounce for 60 cycles, then hold it → zero pulses during the bounce, and exactly one `btn_press[1]` 9 cycles after the final stable edge.
- Drive btn_n low and hold for 100 cycles → `btn_press[3]`, then `btn_long[3]` exactly 64 cycles later, and no second `btn_long`.
- Press btn1..btn3 in the same cycle, starting from `press_count`=254 → three simultaneous press pulses; `press_count` becomes 1 the next cycle (wrap).
- Assert `rst` while btn1 is held in HELD, then release `rst` with btn1 still held → outputs clear immediately, no release pulse, fresh `btn_press[0]` 9 cycles after reset deassertion.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared constants and long-press state encoding for the pushbutton conditioner.
// Imported by every button_debounce file.
package button_debounce_pkg;

    localparam int unsigned LOG2DEBOUNCE_DEFAULT = 16;
    localparam int unsigned LOG2LONG_DEFAULT     = 23;
    localparam int unsigned PRESS_COUNT_W        = 8;

    typedef logic [1:0] hold_state_t;

    localparam hold_state_t StReleased = 2'd0;
    localparam hold_state_t StPressed  = 2'd1;
    localparam hold_state_t StHeld     = 2'd2;

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, long-press FSM,
// and the registered single-cycle press/release/long pulses.
module debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int unsigned LOG2DEBOUNCE = LOG2DEBOUNCE_DEFAULT,
    parameter int unsigned LOG2LONG     = LOG2LONG_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press
);

    logic [1:0]              sync_q;
    logic [LOG2DEBOUNCE-1:0] cnt_q, cnt_d;
    logic                    level_q, level_d;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;
    logic                    long_q, long_d;
    hold_state_t             state_q, state_d;
    logic [LOG2LONG-1:0]     hold_q, hold_d;

    logic sample;
    assign sample = sync_q[1];

    // Any sample matching the current level aborts the window.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample == level_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            cnt_d   = '0;
            level_d = ~level_q;
            rise_d  = sample;
            fall_d  = ~sample;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        long_d  = 1'b0;
        case (state_q)
            StReleased: begin
                if (rise_d) begin
                    state_d = StPressed;
                    hold_d  = '0;
                end
            end
            StPressed: begin
                if (fall_d) begin
                    state_d = StReleased;
                    hold_d  = '0;
                end else if (&hold_q) begin
                    state_d = StHeld;
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StHeld: begin
                if (fall_d) begin
                    state_d = StReleased;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = StReleased;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            long_q  <= 1'b0;
            state_q <= StReleased;
            hold_q  <= '0;
        end else begin
            sync_q  <= {sync_q[0], din};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            long_q  <= long_d;
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign long_press = long_q;

endmodule

// File: rtl/button_debounce.sv
// Pushbutton conditioner: polarity fix-up, per-channel debounce/long-press,
// and a modulo-256 count of press events.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned     N_BTN           = 4,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = 4'b1000,
    parameter int unsigned     LOG2DEBOUNCE    = LOG2DEBOUNCE_DEFAULT,
    parameter int unsigned     LOG2LONG        = LOG2LONG_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_raw,
    output logic [N_BTN-1:0]         btn_level,
    output logic [N_BTN-1:0]         btn_press,
    output logic [N_BTN-1:0]         btn_release,
    output logic [N_BTN-1:0]         btn_long,
    output logic                     any_pressed,
    output logic [PRESS_COUNT_W-1:0] press_count
);

    logic [N_BTN-1:0]         btn_logical;
    logic [PRESS_COUNT_W-1:0] press_inc;
    logic [PRESS_COUNT_W-1:0] count_q;

    assign btn_logical = btn_raw ^ ACTIVE_LOW_MASK;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .LOG2DEBOUNCE(LOG2DEBOUNCE),
            .LOG2LONG    (LOG2LONG)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .din       (btn_logical[i]),
            .level     (btn_level[i]),
            .rise      (btn_press[i]),
            .fall      (btn_release[i]),
            .long_press(btn_long[i])
        );
    end

    always_comb begin
        press_inc = '0;
        for (int i = 0; i < N_BTN; i++) begin
            press_inc = press_inc + {{(PRESS_COUNT_W-1){1'b0}}, btn_press[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + press_inc;
        end
    end

    assign press_count = count_q;
    assign any_pressed = |btn_level;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with a short debounce window (8) and
// long-press threshold (64); expected pulses are queued by the stimulus.
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level, btn_press, btn_release, btn_long;
    logic       any_pressed;
    logic [7:0] press_count;

    button_debounce #(
        .N_BTN          (4),
        .ACTIVE_LOW_MASK(4'b1000),
        .LOG2DEBOUNCE   (3),
        .LOG2LONG       (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long),
        .any_pressed(any_pressed),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  pr;
        logic [3:0]  rl;
        logic [3:0]  lg;
        logic [7:0]  cnt;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  exp_cnt = 8'd0;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Queue one expected pulse; cnt is the press_count visible in that cycle.
    task automatic push(input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] lg,
                        input int unsigned at);
        ev_t e;
        e.cyc = at;
        e.pr  = pr;
        e.rl  = rl;
        e.lg  = lg;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        exp_cnt = exp_cnt + 8'($countones(pr));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any pulse pops the scoreboard; an overdue entry is a missed pulse.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if ((btn_press | btn_release | btn_long) != 4'b0) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pulse: got press=%b release=%b long=%b expected none (cycle %0d)",
                             btn_press, btn_release, btn_long, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_event", 64'({cyc, btn_press, btn_release, btn_long, press_count}),
                          64'({e.cyc, e.pr, e.rl, e.lg, e.cnt}));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_total++;
                $display("FAIL missing_pulse: got none expected press=%b release=%b long=%b at cycle %0d",
                         e.pr, e.rl, e.lg, e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned c;
        int unsigned last_rise;
        rst     = 1'b1;
        btn_raw = 4'b1000;
        wait_cyc(3);
        rst = 1'b0;

        // Idle with btn_n high: nothing moves.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_outputs",
                  64'({btn_level, btn_press, btn_release, btn_long, any_pressed, press_count}),
                  64'd0);
        end

        // Clean btn1 press and release.
        c = cyc; btn_raw = 4'b1001; push(4'b0001, 4'b0000, 4'b0000, c + 10);
        wait_cyc(20);
        check("level_btn1", 64'(btn_level), 64'(4'b0001));
        check("any_pressed_btn1", 64'(any_pressed), 64'd1);
        c = cyc; btn_raw = 4'b1000; push(4'b0000, 4'b0001, 4'b0000, c + 10);
        wait_cyc(20);
        check("level_btn1_released", 64'(btn_level), 64'd0);
        check("count_after_btn1", 64'(press_count), 64'd1);

        // btn2 bounce: 5 high / 2 low, ends holding high.
        last_rise = cyc;
        for (int i = 0; i < 60; i++) begin
            if (i % 7 == 0) last_rise = cyc;
            btn_raw = ((i % 7) < 5) ? 4'b1010 : 4'b1000;
            @(negedge clk);
        end
        push(4'b0010, 4'b0000, 4'b0000, last_rise + 10);
        wait_cyc(20);
        check("level_btn2", 64'(btn_level), 64'(4'b0010));
        c = cyc; btn_raw = 4'b1000; push(4'b0000, 4'b0010, 4'b0000, c + 10);
        wait_cyc(20);

        // btn_n held low: press, long 64 cycles later, no repeat.
        c = cyc; btn_raw = 4'b0000;
        push(4'b1000, 4'b0000, 4'b0000, c + 10);
        push(4'b0000, 4'b0000, 4'b1000, c + 74);
        wait_cyc(100);
        check("level_btn_n", 64'(btn_level), 64'(4'b1000));
        c = cyc; btn_raw = 4'b1000; push(4'b0000, 4'b1000, 4'b0000, c + 10);
        wait_cyc(20);
        check("count_after_btn_n", 64'(press_count), 64'd3);

        // Advance press_count to 254 with btn1 taps.
        while (exp_cnt != 8'd254) begin
            c = cyc; btn_raw = 4'b1001; push(4'b0001, 4'b0000, 4'b0000, c + 10);
            wait_cyc(12);
            c = cyc; btn_raw = 4'b1000; push(4'b0000, 4'b0001, 4'b0000, c + 10);
            wait_cyc(12);
        end
        wait_cyc(2);
        check("count_254", 64'(press_count), 64'd254);

        // Three simultaneous presses wrap the count 254 -> 1.
        c = cyc; btn_raw = 4'b1111; push(4'b0111, 4'b0000, 4'b0000, c + 10);
        wait_cyc(11);
        check("count_wrap", 64'(press_count), 64'd1);
        c = cyc; btn_raw = 4'b1000; push(4'b0000, 4'b0111, 4'b0000, c + 10);
        wait_cyc(20);

        // Reset while btn1 is in HELD, keep holding through reset.
        c = cyc; btn_raw = 4'b1001;
        push(4'b0001, 4'b0000, 4'b0000, c + 10);
        push(4'b0000, 4'b0000, 4'b0001, c + 74);
        wait_cyc(80);
        check("queue_drained_before_reset", 64'(exp_q.size()), 64'd0);
        check("level_held", 64'(btn_level), 64'(4'b0001));
        rst = 1'b1;
        #1;
        check("reset_mid_hold",
              64'({btn_level, btn_press, btn_release, btn_long, any_pressed, press_count}),
              64'd0);
        exp_cnt = 8'd0;
        wait_cyc(3);
        rst = 1'b0;
        c = cyc; push(4'b0001, 4'b0000, 4'b0000, c + 10);
        wait_cyc(20);
        check("level_after_reset", 64'(btn_level), 64'(4'b0001));
        check("count_after_reset", 64'(press_count), 64'd1);
        c = cyc; btn_raw = 4'b1000; push(4'b0000, 4'b0001, 4'b0000, c + 10);
        wait_cyc(20);
        check("queue_drained_final", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
